// File: rtl/audio_pkg.sv
// Shared audio types and defaults for the output path (sample width, I2S slot size, load source).
package audio_pkg;
    localparam int AUDIO_DATA_W  = 16;
    localparam int I2S_SLOT_W    = 32;
    localparam int I2S_BCLK_HALF = 8;

    typedef logic signed [AUDIO_DATA_W-1:0] sample_t;
    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic [1:0] {
        LOAD_ZERO,
        LOAD_HOLD,
        LOAD_REPEAT
    } load_src_e;
endpackage

// File: rtl/i2s_dac_tx_if.sv
// Sample-in / I2S-out bundle between the effect core, the serializer and the DAC pins.
interface i2s_dac_tx_if #(
    parameter int DATA_W = 16
);
    logic              VALID;
    logic [DATA_W-1:0] left_in;
    logic [DATA_W-1:0] right_in;
    logic              clr_status;
    logic              bclk;
    logic              lrclk;
    logic              sdata;
    logic              frame_start;
    logic              underrun;
    logic              overrun;

    modport master (
        output VALID, left_in, right_in, clr_status,
        input  bclk, lrclk, sdata, frame_start, underrun, overrun
    );

    modport slave (
        input  VALID, left_in, right_in, clr_status,
        output bclk, lrclk, sdata, frame_start, underrun, overrun
    );
endinterface

// File: rtl/i2s_bit_timer.sv
// BCLK divider and bit/slot counter; strobes the BCLK falling edge and the frame wrap.
module i2s_bit_timer #(
    parameter int SLOT_W    = 32,
    parameter int BCLK_HALF = 8
) (
    input  logic clk,
    input  logic rst,
    output logic o_bclk,
    output logic o_lrclk,
    output logic o_fall_evt,
    output logic o_frame_wrap
);
    localparam int DIV_W = $clog2(BCLK_HALF);
    localparam int BIT_W = $clog2(2 * SLOT_W);

    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_bclk;
    logic             r_lrclk;
    logic             w_toggle;
    logic             w_fall;
    logic             w_wrap;
    logic [BIT_W-1:0] w_bit_nxt;

    assign w_toggle  = (r_div_cnt == DIV_W'(BCLK_HALF - 1));
    assign w_fall    = w_toggle & r_bclk;
    assign w_wrap    = w_fall & (r_bit_cnt == BIT_W'(2 * SLOT_W - 1));
    assign w_bit_nxt = w_wrap ? '0 : r_bit_cnt + BIT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
        end else begin
            r_div_cnt <= w_toggle ? '0 : r_div_cnt + DIV_W'(1);
            if (w_toggle) r_bclk <= ~r_bclk;
            // lrclk moves with the data on the falling edge, one bit ahead of the MSB
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrclk   <= (w_bit_nxt >= BIT_W'(SLOT_W));
            end
        end
    end

    assign o_bclk       = r_bclk;
    assign o_lrclk      = r_lrclk;
    assign o_fall_evt   = w_fall;
    assign o_frame_wrap = w_wrap;
endmodule

// File: rtl/i2s_dac_tx.sv
// Double-buffered Philips-I2S transmitter for the DAC codec.
// Define I2S_DAC_TX_STEREO_EN to carry right_in in the right slot (default: mono on both slots).
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_W    = AUDIO_DATA_W,
    parameter int SLOT_W    = I2S_SLOT_W,
    parameter int BCLK_HALF = I2S_BCLK_HALF
) (
    input  logic        clk,
    input  logic        rst,
    i2s_dac_tx_if.slave bus
);
    localparam int FRAME_W = 2 * SLOT_W;
`ifdef I2S_DAC_TX_STEREO_EN
    localparam int HOLD_W = 2 * DATA_W;
`else
    localparam int HOLD_W = DATA_W;
`endif

    generate
        if (SLOT_W < DATA_W + 1) begin : g_slot_chk
            $error("i2s_dac_tx: SLOT_W must be >= DATA_W+1");
        end
        if (BCLK_HALF < 2) begin : g_half_chk
            $error("i2s_dac_tx: BCLK_HALF must be >= 2");
        end
    endgenerate

    // one-bit I2S delay, then MSB-first sample, zero padded to the slot end
    function automatic logic [SLOT_W-1:0] f_slot(input logic [DATA_W-1:0] s);
        f_slot = {{(SLOT_W - DATA_W){1'b0}}, s} << (SLOT_W - 1 - DATA_W);
    endfunction

    function automatic logic [FRAME_W-1:0] f_frame(input logic [HOLD_W-1:0] h);
`ifdef I2S_DAC_TX_STEREO_EN
        f_frame = {f_slot(h[HOLD_W-1 -: DATA_W]), f_slot(h[DATA_W-1:0])};
`else
        f_frame = {f_slot(h), f_slot(h)};
`endif
    endfunction

    logic               w_fall_evt;
    logic               w_frame_wrap;
    logic               w_bclk;
    logic               w_lrclk;
    logic               w_capture;
    logic [HOLD_W-1:0]  w_hold_in;
    load_src_e          w_load_src;
    logic [FRAME_W-1:0] w_frame;
    logic               w_set_underrun;
    logic               w_set_overrun;

    logic               r_valid_d;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_hold_valid;
    logic               r_primed;
    logic [FRAME_W-1:0] r_shreg;
    logic               r_sdata;
    logic               r_frame_start;
    logic               r_underrun;
    logic               r_overrun;

    i2s_bit_timer #(
        .SLOT_W    (SLOT_W),
        .BCLK_HALF (BCLK_HALF)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .o_bclk       (w_bclk),
        .o_lrclk      (w_lrclk),
        .o_fall_evt   (w_fall_evt),
        .o_frame_wrap (w_frame_wrap)
    );

`ifdef I2S_DAC_TX_STEREO_EN
    assign w_hold_in = {bus.left_in, bus.right_in};
`else
    logic w_unused_right;
    assign w_hold_in      = bus.left_in;
    assign w_unused_right = ^bus.right_in;
`endif

    assign w_capture = bus.VALID & ~r_valid_d;

    // Once hold has been drained it still holds the last loaded sample, so a repeat reads hold too.
    always_comb begin
        w_load_src = LOAD_ZERO;
        if (r_hold_valid)  w_load_src = LOAD_HOLD;
        else if (r_primed) w_load_src = LOAD_REPEAT;
        w_frame        = (w_load_src == LOAD_ZERO) ? '0 : f_frame(r_hold);
        w_set_underrun = w_frame_wrap & (w_load_src == LOAD_REPEAT);
        w_set_overrun  = w_capture & r_hold_valid & ~w_frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_d     <= 1'b0;
            r_hold        <= '0;
            r_hold_valid  <= 1'b0;
            r_primed      <= 1'b0;
            r_shreg       <= '0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_valid_d     <= bus.VALID;
            r_frame_start <= w_frame_wrap;
            if (w_capture) begin
                r_hold       <= w_hold_in;
                r_hold_valid <= 1'b1;
                r_primed     <= 1'b1;
            end else if (w_frame_wrap) begin
                r_hold_valid <= 1'b0;
            end
            if (w_frame_wrap) begin
                r_sdata <= w_frame[FRAME_W-1];
                r_shreg <= {w_frame[FRAME_W-2:0], 1'b0};
            end else if (w_fall_evt) begin
                r_sdata <= r_shreg[FRAME_W-1];
                r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
            end
            if (w_set_underrun)      r_underrun <= 1'b1;
            else if (bus.clr_status) r_underrun <= 1'b0;
            if (w_set_overrun)       r_overrun  <= 1'b1;
            else if (bus.clr_status) r_overrun  <= 1'b0;
        end
    end

    assign bus.bclk        = w_bclk;
    assign bus.lrclk       = w_lrclk;
    assign bus.sdata       = r_sdata;
    assign bus.frame_start = r_frame_start;
    assign bus.underrun    = r_underrun;
    assign bus.overrun     = r_overrun;
endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
Output serializer stage directly downstream of the flanger core. It captures each processed 16-bit sample on the rising edge of VALID and double-buffers it. It then drives a Philips-I2S stream (BCLK, LRCLK, SDATA) to the board audio DAC codec. It generates all serial timing from clk and reports buffer underrun and overrun.

Parameters:
DATA_W, 16, sample width in bits (signed two's complement).
SLOT_W, 32, BCLK periods per channel slot; must be >= DATA_W+1 (elaboration-time assertion).
BCLK_HALF, 8, clk cycles per BCLK half-period; must be >= 2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
VALID  input  1  sample strobe from the effect core, same clock domain, level signal
left_in  input  DATA_W  processed mono/left sample, sampled on the VALID rise cycle
right_in  input  DATA_W  right sample; used only with STEREO_EN
clr_status  input  1  one-cycle pulse that clears the sticky flags
bclk  output  1  I2S bit clock
lrclk  output  1  word select (0 = left, 1 = right)
sdata  output  1  serial data, MSB first
frame_start  output  1  one-clk pulse when a new frame is loaded
underrun  output  1  sticky flag: a frame repeated the last sample
overrun  output  1  sticky flag: a held sample was overwritten before use

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0. Divider and bit counter 0, hold register empty, primed=0. Frame shift register 0. Reset mid-frame aborts immediately; no partial word completes.
- Capture: valid_d registers VALID. Capture occurs when VALID & ~valid_d. A held-high VALID yields exactly one capture. Capture writes the hold register, sets hold_valid=1 and primed=1.
- Divider: div_cnt counts 0..BCLK_HALF-1; bclk toggles when div_cnt = BCLK_HALF-1. A "fall" event is a 1->0 bclk toggle.
- Bit counter: bit_cnt counts 0..2*SLOT_W-1 and advances on each fall event.
- lrclk is 0 for bit_cnt 0..SLOT_W-1 and 1 otherwise; it changes on the fall event.
- sdata changes only on fall events. The DAC samples on bclk rise.
- Frame layout, per slot:
  - position 0: 0 (I2S one-bit delay)
  - positions 1..DATA_W: sample MSB first
  - positions DATA_W+1..SLOT_W-1: 0
- Frame load: on the fall event where bit_cnt wraps to 0, the 2*SLOT_W shift register loads and frame_start pulses for 1 clk.
  - hold_valid=1: load from hold, clear hold_valid.
  - hold_valid=0 and primed=1: reload the last loaded sample and set underrun.
  - hold_valid=0 and primed=0: load zeros, no flag.
- Simultaneous capture and load in the same clk:
  - The load uses the old hold contents (or follows the repeat rule if empty).
  - The new sample remains in hold with hold_valid=1.
  - overrun is not set.
- Overrun: a capture with hold_valid=1 and no load that cycle overwrites hold (newest wins) and sets overrun.
- Sticky flags: clr_status clears both flags. A set event in the same cycle as clr_status takes priority (flag stays 1).
- Latency: capture to its MSB on sdata is at most one frame plus 2 BCLK periods.
- Mono (no macro): both slots carry the left_in sample.

Optional Feature:
Macro: I2S_DAC_TX_STEREO_EN.
- Defined: hold stores {left_in, right_in}; the left slot carries left_in and the right slot carries right_in. Underrun repeats both.
- Undefined: right_in is unused and both slots carry left_in.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_DATA_W = 16
  - typedef logic signed [AUDIO_DATA_W-1:0] sample_t
  - typedef struct {sample_t l; sample_t r;} stereo_t
  - I2S_SLOT_W default
- One sub-module, i2s_bit_timer: owns div_cnt, bclk, bit_cnt and lrclk, and emits fall_evt and frame_wrap strobes.
- Capture, hold, shift register and flags stay in the top module.

Test Plan:
All scenarios use BCLK_HALF=8, SLOT_W=32, mono.
- Reset: rst=1 for 3 clk -> bclk=lrclk=sdata=frame_start=underrun=overrun=0; first frame after release is all zeros with underrun=0.
- Sample format: VALID rise with left_in=16'hA5C3 -> next frame has lrclk low for 32 BCLKs then high for 32. sdata bits 1..16 of each slot are 1010_0101_1100_0011 and all other positions are 0.
- Underrun: no further VALID after A5C3 -> following frame repeats A5C3 and underrun=1. clr_status pulse -> underrun=0.
- Overrun: rises with 16'h1111 then 16'h2222 within one frame -> next frame carries 2222 and overrun=1.
- VALID held high for 300 clk with left_in changing each clk -> only the value on the first cycle is captured; overrun stays 0.
- Coincident capture: VALID rise with 16'h7FFF on the frame_start clk while hold holds 16'h8000 -> current frame is 8000, next frame is 7FFF, overrun=0.
